// File: rtl/button_controller_if.sv
// Button-side signal bundle for button_controller: raw buttons and frame sync in,
// frame-aligned events and debounced levels out.
interface button_controller_if;
  logic [4:0] btn_raw;
  logic       vsync;
  logic [4:0] operation;
  logic [4:0] btn_level;

  modport master (
    output btn_raw,
    output vsync,
    input  operation,
    input  btn_level
  );

  modport slave (
    input  btn_raw,
    input  vsync,
    output operation,
    output btn_level
  );
endinterface

// File: rtl/button_controller.sv
// Synchronises and debounces five push-buttons, auto-repeats the movement keys and
// commits one event vector per frame on the rising edge of vsync.
module button_controller #(
  parameter int unsigned DEBOUNCE_CYCLES     = 250000,
  parameter int unsigned CNT_W               = 18,
  parameter int unsigned REPEAT_DELAY_FRAMES = 12,
  parameter int unsigned REPEAT_RATE_FRAMES  = 4
) (
  input  logic               clock,
  input  logic               reset,
  button_controller_if.slave bus
);

  localparam int unsigned NumBtn = 5;
  localparam int unsigned NumRep = 3;

  localparam logic [CNT_W-1:0] CntMax     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [5:0]       HoldDelay  = 6'(REPEAT_DELAY_FRAMES);
  localparam logic [5:0]       HoldReload = 6'(REPEAT_DELAY_FRAMES - REPEAT_RATE_FRAMES);

  logic [4:0]       s1_q, s2_q;
  logic [4:0]       level_q, level_d, level_prev_q;
  logic [4:0]       pending_q, pending_d;
  logic [4:0]       op_q, op_d;
  logic [4:0]       rise, rep;
  logic             vs_q, fr, ff;
  logic [CNT_W-1:0] cnt_q [NumBtn];
  logic [CNT_W-1:0] cnt_d [NumBtn];
  logic [5:0]       hold_q [NumRep];
  logic [5:0]       hold_d [NumRep];
  logic [5:0]       hold_inc;

  always_comb begin
    fr       = bus.vsync & ~vs_q;
    ff       = ~bus.vsync & vs_q;
    level_d  = level_q;
    rep      = '0;
    hold_inc = '0;

    for (int b = 0; b < NumBtn; b++) begin
      cnt_d[b] = '0;
      if (s2_q[b] != level_q[b]) begin
        if (cnt_q[b] == CntMax) begin
          level_d[b] = s2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CntOne;
        end
      end
    end

    // Hold counter saturates at the delay by reloading, so it never wraps.
    for (int b = 0; b < NumRep; b++) begin
      hold_d[b] = hold_q[b];
      if (!level_q[b]) begin
        hold_d[b] = '0;
      end else if (ff) begin
        hold_inc = hold_q[b] + 6'd1;
        if (hold_inc == HoldDelay) begin
          rep[b]    = 1'b1;
          hold_d[b] = HoldReload;
        end else begin
          hold_d[b] = hold_inc;
        end
      end
    end

    rise      = level_q & ~level_prev_q;
    op_d      = op_q;
    pending_d = pending_q;
    if (fr) begin
      op_d = pending_q;
      if (pending_q[1:0] == 2'b11) begin
        op_d[1:0] = 2'b00;
      end
      pending_d = '0;
    end
    // New events win over the commit clear and carry into the next frame.
    pending_d = pending_d | rise | rep;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      pending_q    <= '0;
      op_q         <= '0;
      vs_q         <= 1'b1;
      for (int b = 0; b < NumBtn; b++) cnt_q[b] <= '0;
      for (int b = 0; b < NumRep; b++) hold_q[b] <= '0;
    end else begin
      s1_q         <= bus.btn_raw;
      s2_q         <= s1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      pending_q    <= pending_d;
      op_q         <= op_d;
      vs_q         <= bus.vsync;
      for (int b = 0; b < NumBtn; b++) cnt_q[b] <= cnt_d[b];
      for (int b = 0; b < NumRep; b++) hold_q[b] <= hold_d[b];
    end
  end

  assign bus.operation = op_q;
  assign bus.btn_level = level_q;

endmodule

// File: tb/tb_button_controller.sv
// Directed bench for button_controller with short debounce/repeat settings and a
// 20-clock vsync (high for 4 clocks).
module tb_button_controller;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  int   vcnt;
  bit   vs_run;
  logic fr_next;

  button_controller_if bus ();

  button_controller #(
    .DEBOUNCE_CYCLES    (4),
    .CNT_W              (18),
    .REPEAT_DELAY_FRAMES(3),
    .REPEAT_RATE_FRAMES (2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // vsync changes 3 time units after each rising edge; fr_next marks that the
  // coming edge will see a rising vsync.
  initial begin
    logic old_vs;
    bus.vsync = 1'b1;
    fr_next   = 1'b0;
    vcnt      = 3;
    forever begin
      @(posedge clock);
      #3;
      if (vs_run) begin
        old_vs    = bus.vsync;
        vcnt      = (vcnt == 19) ? 0 : vcnt + 1;
        bus.vsync = (vcnt < 4);
        fr_next   = bus.vsync & ~old_vs;
      end else begin
        bus.vsync = 1'b1;
        fr_next   = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Returns just after the edge that commits a frame.
  task automatic wait_fr();
    int n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!fr_next && n < 100);
    if (!fr_next) begin
      errors++;
      $display("FAIL wait_fr: no frame rise within %0d clocks", n);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.btn_raw = 5'b00000;
    vs_run      = 1'b0;
    tick(3);
    checks++;
    if (bus.operation !== 5'b00000) begin
      errors++;
      $display("FAIL reset_op: operation=%b expected 00000", bus.operation);
    end
    checks++;
    if (bus.btn_level !== 5'b00000) begin
      errors++;
      $display("FAIL reset_level: btn_level=%b expected 00000", bus.btn_level);
    end
    reset = 1'b0;
    tick(4);
    checks++;
    if (bus.operation !== 5'b00000) begin
      errors++;
      $display("FAIL release_op: operation=%b expected 00000", bus.operation);
    end
    vs_run = 1'b1;
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00000 || bus.btn_level !== 5'b00000) begin
      errors++;
      $display("FAIL first_frame: operation=%b btn_level=%b expected 00000 00000",
               bus.operation, bus.btn_level);
    end
  endtask

  task automatic test_single_press();
    wait_fr();
    bus.btn_raw = 5'b01000;
    tick(5);
    checks++;
    if (bus.btn_level !== 5'b00000) begin
      errors++;
      $display("FAIL press_level_early: btn_level=%b expected 00000", bus.btn_level);
    end
    tick(1);
    checks++;
    if (bus.btn_level !== 5'b01000) begin
      errors++;
      $display("FAIL press_level: btn_level=%b expected 01000", bus.btn_level);
    end
    tick(4);
    bus.btn_raw = 5'b00000;
    wait_fr();
    checks++;
    if (bus.operation !== 5'b01000) begin
      errors++;
      $display("FAIL press_op: operation=%b expected 01000", bus.operation);
    end
    tick(18);
    checks++;
    if (bus.operation !== 5'b01000) begin
      errors++;
      $display("FAIL press_op_held: operation=%b expected 01000", bus.operation);
    end
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00000 || bus.btn_level !== 5'b00000) begin
      errors++;
      $display("FAIL press_op_after: operation=%b btn_level=%b expected 00000 00000",
               bus.operation, bus.btn_level);
    end
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00000) begin
      errors++;
      $display("FAIL press_no_repeat: operation=%b expected 00000", bus.operation);
    end
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 2; r++) begin
      for (int p = 1; p <= 3; p++) begin
        bus.btn_raw = 5'b00001;
        tick(p);
        bus.btn_raw = 5'b00000;
        for (int g = 0; g < 6; g++) begin
          tick(1);
          checks++;
          if (bus.btn_level !== 5'b00000) begin
            errors++;
            $display("FAIL glitch_level: pulse=%0d btn_level=%b expected 00000",
                     p, bus.btn_level);
          end
        end
      end
    end
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00000) begin
      errors++;
      $display("FAIL glitch_op: operation=%b expected 00000", bus.operation);
    end
  endtask

  task automatic test_repeat();
    logic [12:1] exp_bit;
    logic [4:0]  exp_op;
    exp_bit = 12'b0010_1010_1001; // frame 1 is bit 1 (LSB)
    wait_fr();
    bus.btn_raw = 5'b00100;
    for (int k = 1; k <= 12; k++) begin
      wait_fr();
      exp_op = {2'b00, exp_bit[k], 2'b00};
      checks++;
      if (bus.operation !== exp_op) begin
        errors++;
        $display("FAIL repeat_frame%0d: operation=%b expected %b", k, bus.operation, exp_op);
      end
      if (k == 10) bus.btn_raw = 5'b00000;
    end
  endtask

  task automatic test_lr_cancel();
    wait_fr();
    bus.btn_raw = 5'b00011;
    tick(8);
    bus.btn_raw = 5'b00000;
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00000) begin
      errors++;
      $display("FAIL lr_cancel: operation=%b expected 00000", bus.operation);
    end
    bus.btn_raw = 5'b00010;
    tick(8);
    bus.btn_raw = 5'b00000;
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00010) begin
      errors++;
      $display("FAIL lr_left_only: operation=%b expected 00010", bus.operation);
    end
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00000) begin
      errors++;
      $display("FAIL lr_after: operation=%b expected 00000", bus.operation);
    end
  endtask

  task automatic test_start_on_fr();
    wait_fr();
    tick(13);
    bus.btn_raw = 5'b10000;
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00000) begin
      errors++;
      $display("FAIL start_same_cycle: operation=%b expected 00000", bus.operation);
    end
    bus.btn_raw = 5'b00000;
    wait_fr();
    checks++;
    if (bus.operation !== 5'b10000) begin
      errors++;
      $display("FAIL start_next_frame: operation=%b expected 10000", bus.operation);
    end
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00000) begin
      errors++;
      $display("FAIL start_after: operation=%b expected 00000", bus.operation);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] exp_pre [1:4];
    exp_pre = '{5'b00100, 5'b00000, 5'b00000, 5'b00100};
    wait_fr();
    bus.btn_raw = 5'b00100;
    for (int k = 1; k <= 4; k++) begin
      wait_fr();
      checks++;
      if (bus.operation !== exp_pre[k]) begin
        errors++;
        $display("FAIL hold_pre%0d: operation=%b expected %b", k, bus.operation, exp_pre[k]);
      end
    end
    reset = 1'b1;
    tick(2);
    checks++;
    if (bus.operation !== 5'b00000 || bus.btn_level !== 5'b00000) begin
      errors++;
      $display("FAIL hold_reset: operation=%b btn_level=%b expected 00000 00000",
               bus.operation, bus.btn_level);
    end
    reset = 1'b0;
    tick(1);
    checks++;
    if (bus.btn_level !== 5'b00000) begin
      errors++;
      $display("FAIL hold_relevel_early: btn_level=%b expected 00000", bus.btn_level);
    end
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00100 || bus.btn_level !== 5'b00100) begin
      errors++;
      $display("FAIL hold_fresh_press: operation=%b btn_level=%b expected 00100 00100",
               bus.operation, bus.btn_level);
    end
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00000) begin
      errors++;
      $display("FAIL hold_post1: operation=%b expected 00000", bus.operation);
    end
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00000) begin
      errors++;
      $display("FAIL hold_post2: operation=%b expected 00000", bus.operation);
    end
    wait_fr();
    checks++;
    if (bus.operation !== 5'b00100) begin
      errors++;
      $display("FAIL hold_post_repeat: operation=%b expected 00100", bus.operation);
    end
    bus.btn_raw = 5'b00000;
    wait_fr();
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    vs_run      = 1'b0;
    bus.btn_raw = 5'b00000;
    test_reset();
    test_single_press();
    test_glitch();
    test_repeat();
    test_lr_cancel();
    test_start_on_fr();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
